// File: rtl/mem_req_rr_arbiter.sv
// Two-port burst arbiter for the memory read-address channel. It holds the grant
// for a whole burst and routes response beats back to the port that owns the burst.
//
// state | meaning
// IDLE  | pick a requester and accept its address/len on the handshake
// REQ   | present the latched request to memory until it is accepted
// RESP  | forward beats to the owner until last or the beat count reaches len
module mem_req_rr_arbiter #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32,
    parameter int LEN_W  = 8,
    parameter int RR     = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              io_in_0_valid,
    output logic              io_in_0_ready,
    input  logic [ADDR_W-1:0] io_in_0_bits_addr,
    input  logic [LEN_W-1:0]  io_in_0_bits_len,
    input  logic              io_in_1_valid,
    output logic              io_in_1_ready,
    input  logic [ADDR_W-1:0] io_in_1_bits_addr,
    input  logic [LEN_W-1:0]  io_in_1_bits_len,
    output logic              io_out_valid,
    input  logic              io_out_ready,
    output logic [ADDR_W-1:0] io_out_bits_addr,
    output logic [LEN_W-1:0]  io_out_bits_len,
    output logic              io_out_bits_id,
    input  logic              io_resp_valid,
    output logic              io_resp_ready,
    input  logic [DATA_W-1:0] io_resp_bits_data,
    input  logic              io_resp_bits_last,
    output logic              io_resp_0_valid,
    output logic [DATA_W-1:0] io_resp_0_bits_data,
    output logic              io_resp_0_bits_last,
    output logic              io_resp_1_valid,
    output logic [DATA_W-1:0] io_resp_1_bits_data,
    output logic              io_resp_1_bits_last,
    output logic              io_err
);

    typedef enum logic [1:0] {IDLE, REQ, RESP} state_t;

    state_t             state_q, state_d;
    logic               owner_q, owner_d;
    logic               last_grant_q, last_grant_d;
    logic [ADDR_W-1:0]  addr_q, addr_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic [LEN_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic               any_req, grant_sel, len_hit, burst_end;

    assign any_req = io_in_0_valid | io_in_1_valid;
    assign grant_sel = (io_in_0_valid && io_in_1_valid) ? ((RR != 0) ? ~last_grant_q : 1'b0)
                                                        : io_in_1_valid;
    assign len_hit   = (beat_cnt_q == len_q);
    assign burst_end = io_resp_valid & (io_resp_bits_last | len_hit);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q      <= IDLE;
            owner_q      <= 1'b0;
            last_grant_q <= 1'b1;
            addr_q       <= '0;
            len_q        <= '0;
            beat_cnt_q   <= '0;
        end else begin
            state_q      <= state_d;
            owner_q      <= owner_d;
            last_grant_q <= last_grant_d;
            addr_q       <= addr_d;
            len_q        <= len_d;
            beat_cnt_q   <= beat_cnt_d;
        end
    end

    always_comb begin
        state_d             = state_q;
        owner_d             = owner_q;
        last_grant_d        = last_grant_q;
        addr_d              = addr_q;
        len_d               = len_q;
        beat_cnt_d          = beat_cnt_q;
        io_in_0_ready       = 1'b0;
        io_in_1_ready       = 1'b0;
        io_out_valid        = 1'b0;
        io_resp_ready       = 1'b0;
        io_resp_0_valid     = 1'b0;
        io_resp_0_bits_data = '0;
        io_resp_0_bits_last = 1'b0;
        io_resp_1_valid     = 1'b0;
        io_resp_1_bits_data = '0;
        io_resp_1_bits_last = 1'b0;
        io_err              = 1'b0;

        case (state_q)
            IDLE: begin
                // Ready is masked while reset is held so nothing looks accepted.
                io_in_0_ready = any_req & ~grant_sel & ~reset;
                io_in_1_ready = any_req & grant_sel & ~reset;
                if (any_req) begin
                    owner_d    = grant_sel;
                    addr_d     = grant_sel ? io_in_1_bits_addr : io_in_0_bits_addr;
                    len_d      = grant_sel ? io_in_1_bits_len : io_in_0_bits_len;
                    beat_cnt_d = '0;
                    state_d    = REQ;
                end
            end
            REQ: begin
                io_out_valid = 1'b1;
                if (io_out_ready) state_d = RESP;
            end
            RESP: begin
                io_resp_ready = 1'b1;
                if (io_resp_valid) begin
                    beat_cnt_d = beat_cnt_q + LEN_W'(1);
                    if (owner_q) begin
                        io_resp_1_valid     = 1'b1;
                        io_resp_1_bits_data = io_resp_bits_data;
                        io_resp_1_bits_last = io_resp_bits_last;
                    end else begin
                        io_resp_0_valid     = 1'b1;
                        io_resp_0_bits_data = io_resp_bits_data;
                        io_resp_0_bits_last = io_resp_bits_last;
                    end
                end
                // Ending at equality lets a full-width len run 2**LEN_W beats without wrap.
                if (burst_end) begin
                    io_err       = io_resp_bits_last ^ len_hit;
                    last_grant_d = owner_q;
                    state_d      = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign io_out_bits_addr = addr_q;
    assign io_out_bits_len  = len_q;
    assign io_out_bits_id   = owner_q;

endmodule

// File: tb/tb_mem_req_rr_arbiter.sv
// Bench for mem_req_rr_arbiter: directed scenarios plus randomized bursts checked
// against a transaction-level model of grant order, beat routing and length errors.
module tb_mem_req_rr_arbiter;
    localparam int AW = 32;
    localparam int DW = 32;
    localparam int LW = 8;

    logic clock = 1'b0;
    logic reset;
    logic in0_v, in1_v, out_rdy, resp_v, resp_last;
    logic [AW-1:0] in0_a, in1_a;
    logic [LW-1:0] in0_l, in1_l;
    logic [DW-1:0] resp_d;

    logic in0_r, in1_r, out_v, out_id, rsp_r, r0_v, r0_last, r1_v, r1_last, err;
    logic [AW-1:0] out_a;
    logic [LW-1:0] out_l;
    logic [DW-1:0] r0_d, r1_d;

    logic f_in0_r, f_in1_r, f_out_v, f_out_id, f_rsp_r, f_r0_v, f_r0_last, f_r1_v, f_r1_last, f_err;
    logic [AW-1:0] f_out_a;
    logic [LW-1:0] f_out_l;
    logic [DW-1:0] f_r0_d, f_r1_d;

    int n_checks = 0;
    int n_fail = 0;

    always #5 clock = ~clock;

    mem_req_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RR(1)) dut (
        .clock(clock), .reset(reset),
        .io_in_0_valid(in0_v), .io_in_0_ready(in0_r), .io_in_0_bits_addr(in0_a), .io_in_0_bits_len(in0_l),
        .io_in_1_valid(in1_v), .io_in_1_ready(in1_r), .io_in_1_bits_addr(in1_a), .io_in_1_bits_len(in1_l),
        .io_out_valid(out_v), .io_out_ready(out_rdy), .io_out_bits_addr(out_a), .io_out_bits_len(out_l),
        .io_out_bits_id(out_id), .io_resp_valid(resp_v), .io_resp_ready(rsp_r),
        .io_resp_bits_data(resp_d), .io_resp_bits_last(resp_last),
        .io_resp_0_valid(r0_v), .io_resp_0_bits_data(r0_d), .io_resp_0_bits_last(r0_last),
        .io_resp_1_valid(r1_v), .io_resp_1_bits_data(r1_d), .io_resp_1_bits_last(r1_last),
        .io_err(err)
    );

    // Fixed-priority instance fed the same stimulus; only compared where timing is identical.
    mem_req_rr_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LEN_W(LW), .RR(0)) dut_fp (
        .clock(clock), .reset(reset),
        .io_in_0_valid(in0_v), .io_in_0_ready(f_in0_r), .io_in_0_bits_addr(in0_a), .io_in_0_bits_len(in0_l),
        .io_in_1_valid(in1_v), .io_in_1_ready(f_in1_r), .io_in_1_bits_addr(in1_a), .io_in_1_bits_len(in1_l),
        .io_out_valid(f_out_v), .io_out_ready(out_rdy), .io_out_bits_addr(f_out_a), .io_out_bits_len(f_out_l),
        .io_out_bits_id(f_out_id), .io_resp_valid(resp_v), .io_resp_ready(f_rsp_r),
        .io_resp_bits_data(resp_d), .io_resp_bits_last(resp_last),
        .io_resp_0_valid(f_r0_v), .io_resp_0_bits_data(f_r0_d), .io_resp_0_bits_last(f_r0_last),
        .io_resp_1_valid(f_r1_v), .io_resp_1_bits_data(f_r1_d), .io_resp_1_bits_last(f_r1_last),
        .io_err(f_err)
    );

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic idle_inputs;
        in0_v = 0; in1_v = 0; in0_a = '0; in1_a = '0; in0_l = '0; in1_l = '0;
        out_rdy = 1; resp_v = 0; resp_last = 0; resp_d = '0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick();
        reset = 0;
    endtask

    task automatic test_reset;
        logic [9:0] g;
        logic [AW+LW+2*DW:0] gd;
        idle_inputs();
        in0_v = 1; in1_v = 1; resp_v = 1; resp_last = 1; resp_d = 32'hDEAD_BEEF;
        reset = 0;
        #1 reset = 1;
        #2;
        g = {in0_r, in1_r, out_v, rsp_r, r0_v, r0_last, r1_v, r1_last, err, out_id};
        n_checks++;
        if (g !== 10'b0) begin n_fail++; $display("FAIL reset_ctrl: got %b want 0", g); end
        gd = {out_a, out_l, r0_d, r1_d, 1'b0};
        n_checks++;
        if (gd !== '0) begin n_fail++; $display("FAIL reset_data: got %h want 0", gd); end
        g = {f_in0_r, f_in1_r, f_out_v, f_rsp_r, f_r0_v, f_r0_last, f_r1_v, f_r1_last, f_err, f_out_id};
        n_checks++;
        if (g !== 10'b0) begin n_fail++; $display("FAIL reset_ctrl_fp: got %b want 0", g); end
        gd = {f_out_a, f_out_l, f_r0_d, f_r1_d, 1'b0};
        n_checks++;
        if (gd !== '0) begin n_fail++; $display("FAIL reset_data_fp: got %h want 0", gd); end
        tick();
        reset = 0;
        idle_inputs();
    endtask

    task automatic test_single;
        logic [4:0] g, e;
        do_reset();
        in0_v = 1; in0_a = 32'h8000_0040; in0_l = 8'd3;
        @(negedge clock);
        n_checks++;
        if ({in0_r, in1_r, out_v} !== 3'b100) begin n_fail++; $display("FAIL single_grant: got %b want 100", {in0_r, in1_r, out_v}); end
        tick();
        in0_v = 0; in0_a = 32'h0; in0_l = 8'd0;
        @(negedge clock);
        n_checks++;
        if ({out_v, in0_r, in1_r, rsp_r} !== 4'b1000) begin n_fail++; $display("FAIL single_req_ctl: got %b want 1000", {out_v, in0_r, in1_r, rsp_r}); end
        n_checks++;
        if ({out_a, out_l, out_id} !== {32'h8000_0040, 8'd3, 1'b0}) begin n_fail++; $display("FAIL single_req_fields: got %h/%0d/%b", out_a, out_l, out_id); end
        tick();
        for (int i = 0; i < 4; i++) begin
            resp_v = 1; resp_d = 32'hA0 + i; resp_last = (i == 3);
            @(negedge clock);
            g = {rsp_r, r0_v, r0_last, r1_v, err};
            e = {1'b1, 1'b1, (i == 3), 1'b0, 1'b0};
            n_checks++;
            if (g !== e) begin n_fail++; $display("FAIL single_beat%0d: got %b want %b", i, g, e); end
            n_checks++;
            if (r0_d !== 32'hA0 + i) begin n_fail++; $display("FAIL single_data%0d: got %h want %h", i, r0_d, 32'hA0 + i); end
            tick();
        end
        resp_v = 0; resp_last = 0;
        @(negedge clock);
        n_checks++;
        if ({out_v, rsp_r, in0_r, in1_r, err} !== 5'b0) begin n_fail++; $display("FAIL single_idle: got %b want 0", {out_v, rsp_r, in0_r, in1_r, err}); end
    endtask

    task automatic test_contention;
        do_reset();
        in0_v = 1; in1_v = 1; in0_a = 32'h100; in1_a = 32'h200;
        for (int b = 0; b < 4; b++) begin
            @(negedge clock);
            n_checks++;
            if ({in0_r, in1_r} !== {(b % 2 == 0), (b % 2 == 1)}) begin n_fail++; $display("FAIL rr_grant%0d: got %b", b, {in0_r, in1_r}); end
            n_checks++;
            if ({f_in0_r, f_in1_r} !== 2'b10) begin n_fail++; $display("FAIL fp_grant%0d: got %b want 10", b, {f_in0_r, f_in1_r}); end
            tick();
            @(negedge clock);
            n_checks++;
            if ({out_v, out_id, f_out_v, f_out_id} !== {1'b1, (b % 2 == 1), 1'b1, 1'b0}) begin
                n_fail++; $display("FAIL contention_req%0d: got %b", b, {out_v, out_id, f_out_v, f_out_id});
            end
            tick();
            resp_v = 1; resp_last = 1;
            @(negedge clock);
            n_checks++;
            if ({r0_v, r1_v, f_r0_v, f_r1_v, err, f_err} !== {(b % 2 == 0), (b % 2 == 1), 4'b1000}) begin
                n_fail++; $display("FAIL contention_beat%0d: got %b", b, {r0_v, r1_v, f_r0_v, f_r1_v, err, f_err});
            end
            tick();
            resp_v = 0; resp_last = 0;
        end
        idle_inputs();
    endtask

    task automatic test_backpressure;
        do_reset();
        in1_v = 1; in1_a = 32'h1234_5678; in1_l = 8'd2; out_rdy = 0;
        @(negedge clock);
        n_checks++;
        if ({in0_r, in1_r} !== 2'b01) begin n_fail++; $display("FAIL bp_grant: got %b want 01", {in0_r, in1_r}); end
        tick();
        in1_v = 0; in1_a = '0; in0_v = 1; in0_a = 32'hFFFF_0000; in0_l = 8'd7;
        for (int k = 0; k < 6; k++) begin
            if (k == 5) out_rdy = 1;
            @(negedge clock);
            n_checks++;
            if ({out_v, in0_r, in1_r, rsp_r} !== 4'b1000) begin n_fail++; $display("FAIL bp_hold%0d: got %b want 1000", k, {out_v, in0_r, in1_r, rsp_r}); end
            n_checks++;
            if ({out_a, out_l, out_id} !== {32'h1234_5678, 8'd2, 1'b1}) begin n_fail++; $display("FAIL bp_fields%0d: got %h/%0d/%b", k, out_a, out_l, out_id); end
            tick();
        end
        for (int i = 0; i < 3; i++) begin
            resp_v = 1; resp_last = (i == 2); resp_d = 32'h5000 + i;
            if (i == 2) in0_v = 0;
            @(negedge clock);
            n_checks++;
            if ({rsp_r, r0_v, r1_v, in0_r, err} !== 5'b10100) begin n_fail++; $display("FAIL bp_beat%0d: got %b want 10100", i, {rsp_r, r0_v, r1_v, in0_r, err}); end
            tick();
        end
        resp_v = 0; resp_last = 0;
        @(negedge clock);
        n_checks++;
        if ({out_v, rsp_r} !== 2'b00) begin n_fail++; $display("FAIL bp_idle: got %b want 00", {out_v, rsp_r}); end
    endtask

    task automatic test_mismatch;
        do_reset();
        in0_v = 1; in0_l = 8'd3;
        tick();
        in0_v = 0;
        tick();
        for (int i = 0; i < 3; i++) begin
            resp_v = 1; resp_last = (i == 2);
            @(negedge clock);
            n_checks++;
            if ({r0_v, err} !== {1'b1, (i == 2)}) begin n_fail++; $display("FAIL early_last%0d: got %b", i, {r0_v, err}); end
            tick();
        end
        resp_v = 0; resp_last = 0;
        @(negedge clock);
        n_checks++;
        if ({out_v, rsp_r, err} !== 3'b000) begin n_fail++; $display("FAIL early_last_idle: got %b want 000", {out_v, rsp_r, err}); end
        in0_v = 1; in0_l = 8'd1;
        tick();
        in0_v = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            resp_v = 1; resp_last = 0;
            @(negedge clock);
            n_checks++;
            if ({r0_v, r0_last, err} !== {2'b10, (i == 1)}) begin n_fail++; $display("FAIL no_last%0d: got %b", i, {r0_v, r0_last, err}); end
            tick();
        end
        @(negedge clock);
        n_checks++;
        if ({rsp_r, r0_v, err} !== 3'b000) begin n_fail++; $display("FAIL no_last_idle: got %b want 000", {rsp_r, r0_v, err}); end
        resp_v = 0;
        tick();
    endtask

    task automatic test_stray;
        do_reset();
        resp_v = 1; resp_last = 1; resp_d = $urandom;
        @(negedge clock);
        n_checks++;
        if ({rsp_r, r0_v, r1_v, err, r0_d, r1_d} !== '0) begin n_fail++; $display("FAIL stray_idle: got %b", {rsp_r, r0_v, r1_v, err}); end
        tick();
        in1_v = 1; in1_l = 8'd0; out_rdy = 0;
        tick();
        in1_v = 0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clock);
            n_checks++;
            if ({out_v, rsp_r, r0_v, r1_v, err} !== 5'b10000) begin n_fail++; $display("FAIL stray_req%0d: got %b want 10000", k, {out_v, rsp_r, r0_v, r1_v, err}); end
            tick();
        end
        out_rdy = 1; resp_v = 0;
        tick();
        resp_v = 1; resp_last = 1;
        @(negedge clock);
        n_checks++;
        if ({rsp_r, r0_v, r1_v, err} !== 4'b1010) begin n_fail++; $display("FAIL stray_after: got %b want 1010", {rsp_r, r0_v, r1_v, err}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        in0_v = 1; in0_l = 8'd3; in0_a = 32'hCAFE_0000;
        tick();
        in0_v = 0;
        tick();
        for (int i = 0; i < 2; i++) begin
            resp_v = 1; resp_last = 0; resp_d = 32'h77 + i;
            tick();
        end
        resp_d = 32'h99;
        #1;
        n_checks++;
        if (r0_v !== 1'b1) begin n_fail++; $display("FAIL mid_pre: got %b want 1", r0_v); end
        reset = 1;
        #1;
        n_checks++;
        if ({in0_r, in1_r, out_v, rsp_r, r0_v, r1_v, err, out_id, r0_d, out_a, out_l} !== '0) begin
            n_fail++; $display("FAIL mid_reset_drop: got %b", {in0_r, in1_r, out_v, rsp_r, r0_v, r1_v, err});
        end
        tick();
        reset = 0;
        in1_v = 1; in1_l = 8'd3; in1_a = 32'h0000_BEEF;
        @(negedge clock);
        n_checks++;
        if ({in0_r, in1_r, rsp_r, r0_v, r1_v} !== 5'b01000) begin n_fail++; $display("FAIL mid_regrant: got %b want 01000", {in0_r, in1_r, rsp_r, r0_v, r1_v}); end
        tick();
        in1_v = 0; resp_v = 0;
        tick();
        for (int i = 0; i < 4; i++) begin
            resp_v = 1; resp_last = (i == 3);
            @(negedge clock);
            n_checks++;
            if ({r1_v, r1_last, r0_v, err} !== {1'b1, (i == 3), 2'b00}) begin n_fail++; $display("FAIL mid_beat%0d: got %b", i, {r1_v, r1_last, r0_v, err}); end
            tick();
        end
        resp_v = 0; resp_last = 0;
        @(negedge clock);
        n_checks++;
        if ({out_v, rsp_r} !== 2'b00) begin n_fail++; $display("FAIL mid_idle: got %b want 00", {out_v, rsp_r}); end
    endtask

    task automatic test_long;
        for (int pass = 0; pass < 2; pass++) begin
            do_reset();
            in0_v = 1; in0_l = 8'd255;
            tick();
            in0_v = 0;
            tick();
            for (int i = 0; i < 256; i++) begin
                resp_v = 1; resp_last = (pass == 0) && (i == 255);
                @(negedge clock);
                n_checks++;
                if ({r0_v, err} !== {1'b1, (pass == 1) && (i == 255)}) begin n_fail++; $display("FAIL long%0d_beat%0d: got %b", pass, i, {r0_v, err}); end
                tick();
            end
            @(negedge clock);
            n_checks++;
            if ({rsp_r, r0_v} !== 2'b00) begin n_fail++; $display("FAIL long%0d_end: got %b want 00", pass, {rsp_r, r0_v}); end
            resp_v = 0; resp_last = 0;
        end
    endtask

    task automatic test_random;
        logic [1:0] pend;
        logic [AW-1:0] pa [2];
        logic [LW-1:0] pl [2];
        int last_win, w, stall, last_at;
        logic wb, exp_end, exp_err, done;
        do_reset();
        last_win = 1;
        pend = 2'b00;
        for (int t = 0; t < 60; t++) begin
            for (int p = 0; p < 2; p++)
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1; pa[p] = $urandom; pl[p] = LW'($urandom_range(0, 6));
                end
            if (pend == 2'b00) begin pend[0] = 1; pa[0] = $urandom; pl[0] = LW'($urandom_range(0, 6)); end
            in0_v = pend[0]; in0_a = pa[0]; in0_l = pl[0];
            in1_v = pend[1]; in1_a = pa[1]; in1_l = pl[1];
            out_rdy = 1'($urandom_range(0, 1)); resp_v = 0; resp_last = 0;
            w = (pend == 2'b11) ? 1 - last_win : (pend[1] ? 1 : 0);
            wb = 1'(w);
            @(negedge clock);
            n_checks++;
            if ({in0_r, in1_r, out_v} !== {~wb, wb, 1'b0}) begin n_fail++; $display("FAIL rnd%0d_grant: got %b want port %0d", t, {in0_r, in1_r, out_v}, w); end
            tick();
            pend[w] = 0;
            if (w == 0) begin in0_v = 0; in0_a = $urandom; in0_l = '1; end
            else begin in1_v = 0; in1_a = $urandom; in1_l = '1; end
            stall = $urandom_range(0, 3);
            for (int s = 0; s <= stall; s++) begin
                out_rdy = (s == stall);
                resp_v = 1'($urandom_range(0, 1)); resp_last = 1'($urandom_range(0, 1));
                @(negedge clock);
                n_checks++;
                if ({out_v, in0_r, in1_r, rsp_r, r0_v, r1_v} !== 6'b100000) begin n_fail++; $display("FAIL rnd%0d_req: got %b want 100000", t, {out_v, in0_r, in1_r, rsp_r, r0_v, r1_v}); end
                n_checks++;
                if ({out_a, out_l, out_id} !== {pa[w], pl[w], wb}) begin n_fail++; $display("FAIL rnd%0d_fields: got %h/%0d/%b want %h/%0d/%b", t, out_a, out_l, out_id, pa[w], pl[w], wb); end
                tick();
            end
            last_at = $urandom_range(0, int'(pl[w]) + 2);
            done = 0;
            for (int c = 0, i = 0; c < 40 && !done; c++) begin
                if ($urandom_range(0, 3) == 0) begin
                    resp_v = 0; resp_last = 1'($urandom_range(0, 1));
                    @(negedge clock);
                    n_checks++;
                    if ({rsp_r, r0_v, r1_v, err, in0_r, in1_r} !== 6'b100000) begin n_fail++; $display("FAIL rnd%0d_gap: got %b want 100000", t, {rsp_r, r0_v, r1_v, err, in0_r, in1_r}); end
                end else begin
                    resp_v = 1; resp_last = (i == last_at); resp_d = $urandom;
                    exp_end = (i == last_at) || (i == int'(pl[w]));
                    exp_err = exp_end && ((i == last_at) != (i == int'(pl[w])));
                    @(negedge clock);
                    n_checks++;
                    if ({rsp_r, r0_v, r1_v, err, in0_r, in1_r} !== {1'b1, ~wb, wb, exp_err, 2'b00}) begin
                        n_fail++; $display("FAIL rnd%0d_beat%0d: got %b want %b", t, i, {rsp_r, r0_v, r1_v, err, in0_r, in1_r}, {1'b1, ~wb, wb, exp_err, 2'b00});
                    end
                    n_checks++;
                    if ((wb ? {r1_d, r1_last} : {r0_d, r0_last}) !== {resp_d, resp_last}) begin
                        n_fail++; $display("FAIL rnd%0d_data%0d: got %h want %h", t, i, (wb ? r1_d : r0_d), resp_d);
                    end
                    i++;
                    done = exp_end;
                end
                tick();
            end
            resp_v = 0; resp_last = 0;
            last_win = w;
        end
        idle_inputs();
        tick();
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_contention();
        test_backpressure();
        test_mismatch();
        test_stray();
        test_reset_mid();
        test_long();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_req_rr_arbiter.md
Name: mem_req_rr_arbiter

Overview:
Shares the single memory read-address channel and its burst response channel between two requesters: port 0 (icache refill) and port 1 (dcache refill). The arbiter grants one requester and holds the grant for the whole burst. It routes response beats back to the owner and releases the grant on the final beat. It sits between the cache refill units and the AXI-lite-style memory bridge, replacing a purely combinational priority mux.

Parameters:
ADDR_W, 32, request address width
DATA_W, 32, response data width
LEN_W, 8, burst length field width (beats minus one)
RR, 1, 1 = round-robin between ports; 0 = fixed priority, port 0 wins

Ports:
clock  in  1  system clock
reset  in  1  asynchronous, active-high reset
io_in_0_valid  in  1  port 0 request valid
io_in_0_ready  out  1  port 0 request accepted this cycle
io_in_0_bits_addr  in  ADDR_W  port 0 burst start address
io_in_0_bits_len  in  LEN_W  port 0 beats minus one
io_in_1_valid / io_in_1_ready / io_in_1_bits_addr / io_in_1_bits_len  as port 0, for port 1
io_out_valid  out  1  request to memory valid
io_out_ready  in  1  memory accepts request
io_out_bits_addr  out  ADDR_W  latched address
io_out_bits_len  out  LEN_W  latched length
io_out_bits_id  out  1  owner port index
io_resp_valid  in  1  memory response beat valid
io_resp_ready  out  1  arbiter accepts response beat
io_resp_bits_data  in  DATA_W  beat data
io_resp_bits_last  in  1  final beat marker
io_resp_0_valid / io_resp_0_bits_data / io_resp_0_bits_last  out  1/DATA_W/1  beats routed to port 0
io_resp_1_valid / io_resp_1_bits_data / io_resp_1_bits_last  out  1/DATA_W/1  beats routed to port 1
io_err  out  1  one-cycle pulse: burst length mismatch

Behaviour:
- Clocking and reset: one clock, `clock`. `reset` is asynchronous and active-high. On reset: state=IDLE, owner=0, last_grant=1 (port 0 wins first), beat_cnt=0. All valid and ready outputs, and io_err, are 0. Data outputs are 0.
- FSM states:
  - IDLE: combinational grant.
    - RR=1: with both ports valid, the grant goes to the port not equal to last_grant.
    - RR=0: port 0 always wins.
    - The granted port sees in_x_ready=1 in that cycle; the other sees 0.
    - On the handshake (cycle N): latch addr, len and owner; set beat_cnt=0; go to REQ.
    - No valid request: remain in IDLE.
  - REQ: io_out_valid=1 from cycle N+1. Fields are stable from the latches. Both in_x_ready=0. On io_out_ready: go to RESP.
  - RESP: io_resp_ready=1.
    - Each io_resp_valid beat is forwarded combinationally to io_resp_<owner>, with the same cycle's data and last. The other port's valid is 0. beat_cnt increments on each beat.
    - Burst ends on the beat where resp_last=1, or where beat_cnt==len, whichever occurs first.
    - At burst end: go to IDLE and set last_grant=owner.
    - Mismatch pulses io_err for one cycle, in the same cycle as the ending beat. A mismatch is last=1 with beat_cnt!=len, or beat_cnt==len with last=0.
- Responses outside RESP: io_resp_ready=0 and nothing is forwarded.
- Requests during REQ/RESP: held off (ready=0). Requesters keep valid asserted. There is no queueing.
- Minimum occupancy: handshake in IDLE, then 1 cycle in REQ (if io_out_ready is high), then ≥1 cycle in RESP. A new grant is possible in the cycle after the last beat.
- beat_cnt is LEN_W bits. len=255 gives 256 beats with no overflow, because the burst ends at equality.
- Reset mid-burst: all outputs drop immediately and asynchronously. Subsequent memory beats are ignored until a new grant reaches RESP.
- io_in_x_ready never depends on io_out_ready. There is no combinational path from io_out_ready to any input ready.

Test Plan:
- Single request: port 0 addr=0x8000_0040, len=3 → in_0_ready=1 for 1 cycle; out_valid next cycle with addr 0x8000_0040, len 3, id 0; 4 beats (0xA0..0xA3, last on 4th) appear on io_resp_0 only; IDLE afterwards; io_err=0.
- Contention: both ports continuously valid after reset, RR=1 → grants go 0,1,0,1 across 4 bursts of len 0. Same stimulus with RR=0 → port 0 wins all 4.
- Backpressure: io_out_ready low for 5 cycles in REQ → out_valid held high with addr/len/id stable; in_0_ready=in_1_ready=0 throughout; proceeds on the first ready cycle.
- Length mismatch: len=3, resp_last asserted on beat 2 → io_err pulses on that beat, return to IDLE. len=1 with last never asserted → burst ends on beat 2 with io_err=1.
- Stray responses: io_resp_valid=1 while in IDLE and REQ → io_resp_ready=0; io_resp_0_valid=io_resp_1_valid=0.
- Reset mid-RESP after 2 of 4 beats → all outputs 0 immediately, last_grant=1. The next request from port 1 is granted normally and completes with beat_cnt starting at 0.
